flag_register_unit: RTL and testbench

FLAG_REGISTER_UNIT -- requirements
Module: flag_register_unit

---
 rtl/flag_register_unit.sv | 132 +++++++++++++
 tb/tb_flag_register_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_register_unit.sv
// Z/N/C flag register with ordered update rules and a 2-deep shadow stack
// used for interrupt entry (push) and RTI (pop).
//
// state | meaning
// EMPTY | shadow stack holds no entries
// ONE   | one saved flag set (top = entry 0)
// FULL  | two saved flag sets (top = entry 1)
module flag_register_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic [2:0]  upd_mask,
  input  logic        setc,
  input  logic        clrc,
  input  logic        jmp_clr_en,
  input  logic [1:0]  jmp_clr_sel,
  input  logic        int_save,
  input  logic        rti_restore,
  output logic [2:0]  flags,
  output logic [2:0]  flags_fwd,
  output logic [1:0]  stk_depth,
  output logic        stk_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stk_state_e;

  stk_state_e state_q, state_d;
  logic [2:0] flags_q, flags_d;
  logic [2:0] stk0_q, stk0_d;
  logic [2:0] stk1_q, stk1_d;
  logic       err_q, err_d;

  logic [2:0] alu_flags;
  logic [2:0] flags_a, flags_b, flags_c;
  logic [2:0] stk_top;
  logic       push_ok, pop_ok;

  // Ordered flag update: ALU, then SETC/CLRC, then jump clear.
  always_comb begin
    alu_flags = {alu_carry, alu_result[15], (alu_result == 16'h0000)};
    flags_a   = alu_valid ? ((flags_q & ~upd_mask) | (alu_flags & upd_mask)) : flags_q;
    flags_b   = flags_a;
    if (setc && !clrc) begin
      flags_b[2] = 1'b1;
    end else if (clrc && !setc) begin
      flags_b[2] = 1'b0;
    end
    flags_c = flags_b;
    if (jmp_clr_en) begin
      case (jmp_clr_sel)
        2'd0:    flags_c[0] = 1'b0;
        2'd1:    flags_c[1] = 1'b0;
        2'd2:    flags_c[2] = 1'b0;
        default: flags_c = flags_b;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    stk0_d  = stk0_q;
    stk1_d  = stk1_q;
    err_d   = err_q;
    flags_d = flags_c;
    pop_ok  = rti_restore && (state_q != EMPTY);
    // A simultaneous restore always wins; the save is dropped.
    push_ok = int_save && !rti_restore && (state_q != FULL);
    stk_top = (state_q == FULL) ? stk1_q : stk0_q;

    case (state_q)
      EMPTY: begin
        if (push_ok) begin
          stk0_d  = flags_q;
          state_d = ONE;
        end
      end
      ONE: begin
        if (pop_ok) begin
          state_d = EMPTY;
        end else if (push_ok) begin
          stk1_d  = flags_q;
          state_d = FULL;
        end
      end
      FULL: begin
        if (pop_ok) begin
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (pop_ok) begin
      flags_d = stk_top;
    end

    if ((setc && clrc) ||
        (int_save && rti_restore) ||
        (int_save && (state_q == FULL)) ||
        (rti_restore && (state_q == EMPTY))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      flags_q <= 3'b000;
      stk0_q  <= 3'b000;
      stk1_q  <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      stk0_q  <= stk0_d;
      stk1_q  <= stk1_d;
      err_q   <= err_d;
    end
  end

  assign flags     = flags_q;
  assign flags_fwd = rst_n ? flags_d : 3'b000;
  assign stk_depth = state_q;
  assign stk_err   = err_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Scoreboard bench for flag_register_unit: directed scenarios plus random
// stimulus, checked against a queue-based behavioural model.
module tb_flag_register_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic [2:0]  upd_mask;
  logic        setc, clrc;
  logic        jmp_clr_en;
  logic [1:0]  jmp_clr_sel;
  logic        int_save, rti_restore;
  logic [2:0]  flags, flags_fwd;
  logic [1:0]  stk_depth;
  logic        stk_err;

  flag_register_unit dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_result(alu_result),
    .alu_carry(alu_carry), .upd_mask(upd_mask), .setc(setc), .clrc(clrc),
    .jmp_clr_en(jmp_clr_en), .jmp_clr_sel(jmp_clr_sel), .int_save(int_save),
    .rti_restore(rti_restore), .flags(flags), .flags_fwd(flags_fwd),
    .stk_depth(stk_depth), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;
    logic [1:0] depth;
    logic       err;
    int         idx;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         step_idx = 0;

  // Reference model: flags, sticky error, and the shadow stack as a queue.
  logic [2:0] m_flags = 3'b000;
  logic       m_err = 1'b0;
  logic [2:0] m_stk[$];

  task automatic idle();
    rst_n = 1'b1; alu_valid = 1'b0; alu_result = 16'h0; alu_carry = 1'b0;
    upd_mask = 3'b000; setc = 1'b0; clrc = 1'b0; jmp_clr_en = 1'b0;
    jmp_clr_sel = 2'd3; int_save = 1'b0; rti_restore = 1'b0;
  endtask

  // Called just after a negedge with inputs set; returns after the next negedge.
  task automatic step();
    logic [2:0] nf;
    logic [2:0] alu_f;
    logic       ne;
    exp_t       e;
    #1;
    if (!rst_n) begin
      nf = 3'b000; ne = 1'b0; m_stk.delete();
    end else begin
      nf = m_flags; ne = m_err;
      alu_f = {alu_carry, alu_result[15], (alu_result == 16'h0000)};
      if (alu_valid)
        for (int i = 0; i < 3; i++) if (upd_mask[i]) nf[i] = alu_f[i];
      if (setc && clrc) ne = 1'b1;
      else if (setc) nf[2] = 1'b1;
      else if (clrc) nf[2] = 1'b0;
      if (jmp_clr_en && jmp_clr_sel != 2'd3) nf[jmp_clr_sel] = 1'b0;
      if (rti_restore) begin
        if (m_stk.size() > 0) nf = m_stk.pop_back();
        else ne = 1'b1;
      end
      if (int_save) begin
        if (rti_restore) ne = 1'b1;
        else if (m_stk.size() < 2) m_stk.push_back(m_flags);
        else ne = 1'b1;
      end
    end
    checks++;
    if (flags_fwd !== nf) begin
      errors++;
      $display("FAIL fwd step %0d: got %b expected %b", step_idx, flags_fwd, nf);
    end
    m_flags = nf;
    m_err = ne;
    e.flags = nf; e.depth = 2'(m_stk.size()); e.err = ne; e.idx = step_idx;
    sb_q.push_back(e);
    step_idx++;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [2:0] ef, input logic [1:0] ed,
                     input logic ee);
    checks++;
    if (flags !== ef || stk_depth !== ed || stk_err !== ee) begin
      errors++;
      $display("FAIL %s: got flags=%b depth=%0d err=%b expected flags=%b depth=%0d err=%b",
               name, flags, stk_depth, stk_err, ef, ed, ee);
    end
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; step();
  endtask

  task automatic do_alu(input logic [15:0] r, input logic c, input logic [2:0] m);
    idle(); alu_valid = 1'b1; alu_result = r; alu_carry = c; upd_mask = m; step();
  endtask

  // Monitor: one registered result per clock once stimulus has been issued.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (flags !== e.flags || stk_depth !== e.depth || stk_err !== e.err) begin
          errors++;
          $display("FAIL scoreboard step %0d: got flags=%b depth=%0d err=%b expected flags=%b depth=%0d err=%b",
                   e.idx, flags, stk_depth, stk_err, e.flags, e.depth, e.err);
        end
      end
    end
  end

  initial begin : stim
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    chk("reset", 3'b000, 2'd0, 1'b0);

    // ALU update
    do_alu(16'h0000, 1'b1, 3'b111);
    chk("alu_all", 3'b101, 2'd0, 1'b0);
    do_alu(16'h8000, 1'b0, 3'b010);
    chk("alu_n_only", 3'b111, 2'd0, 1'b0);

    // Jump clear beats ALU write of N
    idle(); jmp_clr_en = 1'b1; jmp_clr_sel = 2'd1; alu_valid = 1'b1;
    alu_result = 16'h8001; upd_mask = 3'b010; step();
    chk("jmp_clr", 3'b101, 2'd0, 1'b0);

    // Nested interrupt
    do_reset();
    do_alu(16'h0000, 1'b0, 3'b111);
    chk("nest_start", 3'b001, 2'd0, 1'b0);
    idle(); int_save = 1'b1; step();
    do_alu(16'h8000, 1'b1, 3'b111);
    chk("nest_alu", 3'b110, 2'd1, 1'b0);
    idle(); int_save = 1'b1; step();
    do_alu(16'h0001, 1'b0, 3'b111);
    chk("nest_clear", 3'b000, 2'd2, 1'b0);
    idle(); rti_restore = 1'b1; step();
    chk("nest_rti1", 3'b110, 2'd1, 1'b0);
    idle(); rti_restore = 1'b1; step();
    chk("nest_rti2", 3'b001, 2'd0, 1'b0);

    // Overflow and underflow
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); int_save = 1'b1; step();
    end
    chk("overflow", 3'b000, 2'd2, 1'b1);
    do_reset();
    idle(); rti_restore = 1'b1; step();
    chk("underflow", 3'b000, 2'd0, 1'b1);

    // Conflicts
    do_reset();
    idle(); setc = 1'b1; step();
    idle(); setc = 1'b1; clrc = 1'b1; step();
    chk("setc_clrc", 3'b100, 2'd0, 1'b1);
    do_reset();
    idle(); setc = 1'b1; step();
    idle(); int_save = 1'b1; step();
    idle(); clrc = 1'b1; step();
    idle(); int_save = 1'b1; rti_restore = 1'b1; step();
    chk("save_rti", 3'b100, 2'd0, 1'b1);

    // Reset mid-interrupt discards the stack
    do_reset();
    do_alu(16'h0000, 1'b1, 3'b111);
    do_alu(16'h8000, 1'b0, 3'b010);
    idle(); int_save = 1'b1; step();
    idle(); int_save = 1'b1; step();
    chk("pre_reset", 3'b111, 2'd2, 1'b0);
    do_reset();
    chk("mid_reset", 3'b000, 2'd0, 1'b0);
    idle(); rti_restore = 1'b1; step();
    chk("post_reset_rti", 3'b000, 2'd0, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst_n       = ($urandom_range(0, 39) != 0);
      alu_valid   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       alu_result = 16'h0000;
        1:       alu_result = 16'h8000;
        default: alu_result = 16'($urandom);
      endcase
      alu_carry   = 1'($urandom_range(0, 1));
      upd_mask    = 3'($urandom_range(0, 7));
      setc        = ($urandom_range(0, 4) == 0);
      clrc        = ($urandom_range(0, 4) == 0);
      jmp_clr_en  = ($urandom_range(0, 2) == 0);
      jmp_clr_sel = 2'($urandom_range(0, 3));
      int_save    = ($urandom_range(0, 3) == 0);
      rti_restore = ($urandom_range(0, 3) == 0);
      step();
    end

    idle();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
